// File: rtl/seg_scan_scheduler_if.sv
// Load handshake bundle for the seven-segment scan scheduler.
// Carries a full display value (one nibble per digit) from a producer
// to the scheduler under a valid/ready handshake.
//   load_valid  producer -> scheduler  new display value offered
//   load_ready  scheduler -> producer  scheduler can take a value
//   load_data   producer -> scheduler  nibble i = digit i, digit 0 in bits [3:0]
interface seg_scan_scheduler_if #(
  parameter int NUM_DIGITS = 8
);
  logic                      load_valid;
  logic                      load_ready;
  logic [4*NUM_DIGITS-1:0]   load_data;

  modport master (
    output load_valid,
    output load_data,
    input  load_ready
  );

  modport slave (
    input  load_valid,
    input  load_data,
    output load_ready
  );
endinterface

// File: rtl/seg_scan_scheduler.sv
// Scan sequencer for a multi-digit seven-segment display.
// Time-multiplexes NUM_DIGITS digits once per frame, with a dead-time window
// at the start of every digit slot to suppress ghosting. Display values are
// double-buffered: a value accepted on the load bus waits in a pending buffer
// and is copied to the active buffer only on the last cycle of a frame.
// Ports:
//   clk            system clock, rising edge
//   reset          asynchronous active-low reset
//   load_bus       slave side of the load handshake (valid/ready/data)
//   digit_en_mask  per-digit enable, 1 = digit may light (sampled every cycle)
//   lz_blank       blank leading-zero digits (sampled at frame transfer)
//   digit_select   active-low anode enables, at most one bit low
//   count4bit      nibble of the digit owning the current slot
//   blank          1 when no digit is lit this cycle
//   frame_done     1-cycle pulse on the last cycle of each frame
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_BLANK | dead time at slot start, all anodes off
// ST_SHOW  | remainder of slot, anode idx on if enabled and not lz-blanked
module seg_scan_scheduler #(
  parameter int CLK_HZ       = 100_000_000,
  parameter int FRAME_HZ     = 1000,
  parameter int NUM_DIGITS   = 8,
  parameter int BLANK_CYCLES = 100
) (
  input  logic                  clk,
  input  logic                  reset,
  seg_scan_scheduler_if.slave   load_bus,
  input  logic [NUM_DIGITS-1:0] digit_en_mask,
  input  logic                  lz_blank,
  output logic [NUM_DIGITS-1:0] digit_select,
  output logic [3:0]            count4bit,
  output logic                  blank,
  output logic                  frame_done
);

  localparam int DIGIT_PERIOD = CLK_HZ / (FRAME_HZ * NUM_DIGITS);
  localparam int CNT_W        = $clog2(DIGIT_PERIOD);
  localparam int IDX_W        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DW           = 4 * NUM_DIGITS;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIGIT_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_SHOW = CNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic {ST_BLANK, ST_SHOW} state_t;

  state_t                state, state_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic [IDX_W-1:0]      idx, idx_nxt;
  logic [DW-1:0]         active, active_nxt;
  logic [DW-1:0]         pending, pending_nxt;
  logic                  pending_full, pending_full_nxt;
  logic [NUM_DIGITS-1:0] lz_mask, lz_mask_nxt;
  logic [NUM_DIGITS-1:0] lz_new;
  logic                  zero_run;

  logic [NUM_DIGITS-1:0] digit_select_nxt;
  logic [3:0]            count4bit_nxt;
  logic                  blank_nxt;
  logic                  frame_done_nxt;

  logic                  slot_wrap;
  logic                  frame_last;
  logic                  accept;
  logic                  lit_nxt;

  assign load_bus.load_ready = !pending_full;

  // Leading-zero mask for the pending value: a digit is blanked while every
  // nibble from the top down to it is zero. Digit 0 is always shown.
  always_comb begin
    lz_new   = '0;
    zero_run = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_run  = zero_run & (pending[4*i +: 4] == 4'd0);
      lz_new[i] = lz_blank & zero_run;
    end
  end

  // Outputs are registered from the next-cycle view so that each output
  // register lines up with the counter value it describes.
  always_comb begin
    state_nxt        = state;
    cnt_nxt          = cnt + 1'b1;
    idx_nxt          = idx;
    active_nxt       = active;
    pending_nxt      = pending;
    pending_full_nxt = pending_full;
    lz_mask_nxt      = lz_mask;
    digit_select_nxt = '1;
    blank_nxt        = 1'b1;
    lit_nxt          = 1'b0;

    slot_wrap  = (cnt == CNT_LAST);
    frame_last = slot_wrap && (idx == IDX_LAST);
    accept     = load_bus.load_valid && !pending_full;

    if (slot_wrap) begin
      cnt_nxt = '0;
      idx_nxt = (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end

    case (state)
      ST_BLANK: if (cnt_nxt == CNT_SHOW) state_nxt = ST_SHOW;
      ST_SHOW:  if (slot_wrap) state_nxt = (BLANK_CYCLES == 0) ? ST_SHOW : ST_BLANK;
      default:  state_nxt = ST_BLANK;
    endcase

    // Transfer uses the pre-edge pending_full, so a value accepted on the
    // very last frame cycle waits for the following frame.
    if (frame_last && pending_full) begin
      active_nxt       = pending;
      lz_mask_nxt      = lz_new;
      pending_full_nxt = 1'b0;
    end

    if (accept) begin
      pending_nxt      = load_bus.load_data;
      pending_full_nxt = 1'b1;
    end

    lit_nxt = (state_nxt == ST_SHOW) && digit_en_mask[idx_nxt] && !lz_mask_nxt[idx_nxt];
    if (lit_nxt) begin
      digit_select_nxt = ~(NUM_DIGITS'(1) << idx_nxt);
      blank_nxt        = 1'b0;
    end

    count4bit_nxt  = active_nxt[4*idx_nxt +: 4];
    frame_done_nxt = (cnt_nxt == CNT_LAST) && (idx_nxt == IDX_LAST);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_BLANK;
      cnt          <= '0;
      idx          <= '0;
      active       <= '0;
      pending      <= '0;
      pending_full <= 1'b0;
      lz_mask      <= '0;
      digit_select <= '1;
      count4bit    <= 4'd0;
      blank        <= 1'b1;
      frame_done   <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      idx          <= idx_nxt;
      active       <= active_nxt;
      pending      <= pending_nxt;
      pending_full <= pending_full_nxt;
      lz_mask      <= lz_mask_nxt;
      digit_select <= digit_select_nxt;
      count4bit    <= count4bit_nxt;
      blank        <= blank_nxt;
      frame_done   <= frame_done_nxt;
    end
  end

endmodule
